// File: rtl/tone_pkg.sv
// Shared constants for the tone generator: note frequency table and the
// elaboration-time half-period calculation used to size and fill the ROM.
package tone_pkg;

   localparam logic [3:0] TONE_SILENT = 4'd0;

   // C4..C6 major scale in Hz; entry 0 is the silent code.
   localparam int unsigned NOTE_HZ [16] = '{
      0,   262, 294, 330, 349, 392, 440, 494,
      523, 587, 659, 698, 784, 880, 988, 1047
   };

   function automatic int unsigned half_period(input int unsigned clk_hz,
                                               input logic [3:0]  code);
      if (code == TONE_SILENT) begin
         return 0;
      end
      return clk_hz / (2 * NOTE_HZ[code]);
   endfunction

endpackage

// File: rtl/tone_rom.sv
// Combinational note-code to half-period lookup; every entry is a
// constant folded at elaboration from the package frequency table.
module tone_rom
   import tone_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 1_000_000,
   parameter int          CNT_W       = 11
) (
   input  logic [3:0]       code_i,
   output logic [CNT_W-1:0] half_o
);

   logic [CNT_W-1:0] rom [16];

   for (genvar k = 0; k < 16; k++) begin : g_rom
      assign rom[k] = CNT_W'(half_period(CLK_FREQ_HZ, 4'(k)));
   end

   assign half_o = rom[code_i];

endmodule

// File: rtl/tone_converter.sv
// 50 %-duty square-wave generator: a half-period counter toggles the
// registered output; any silence or note change restarts the phase.
module tone_converter
   import tone_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 1_000_000,
   // +1 so the largest half-period itself always fits, not just its count.
   parameter int          CNT_W       = $clog2(half_period(CLK_FREQ_HZ, 4'd1) + 1)
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       EN,
   input  logic [3:0] B_in,
   output logic       D_out
);

   logic [CNT_W-1:0] cnt_q,  cnt_d;
   logic [3:0]       code_q, code_d;
   logic             tone_q, tone_d;
   logic [CNT_W-1:0] half;
   logic             restart;

   tone_rom #(
      .CLK_FREQ_HZ (CLK_FREQ_HZ),
      .CNT_W       (CNT_W)
   ) u_rom (
      .code_i (B_in),
      .half_o (half)
   );

   assign restart = !EN || (B_in == TONE_SILENT) || (B_in != code_q);

   // NOTE: defaults first so every path assigns every output -- no latches.
   always_comb begin
      cnt_d  = cnt_q + CNT_W'(1);
      code_d = code_q;
      tone_d = tone_q;
      if (restart) begin
         cnt_d  = '0;
         tone_d = 1'b0;
         code_d = B_in;
      end else if (cnt_q == half - CNT_W'(1)) begin
         cnt_d  = '0;
         tone_d = ~tone_q;
      end
   end

   // NOTE: state registers use non-blocking assignments only.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         cnt_q  <= '0;
         code_q <= TONE_SILENT;
         tone_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         code_q <= code_d;
         tone_q <= tone_d;
      end
   end

   assign D_out = tone_q;

endmodule

// File: tb/tb_tone_converter.sv
// Scoreboarded bench for tone_converter: an edge-age reference model feeds
// an expected-output queue that a negedge monitor drains against D_out.
module tb_tone_converter;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       EN  = 1'b1;
   logic [3:0] B_in = 4'd3;
   logic       D_out;

   int checks = 0;
   int errors = 0;

   logic exp_q [$];

   // Reference model: output is the parity of (edges since restart / half).
   int unsigned hz [16] = '{0, 262, 294, 330, 349, 392, 440, 494,
                            523, 587, 659, 698, 784, 880, 988, 1047};
   int   m_age  = 0;
   int   m_prev = 0;
   logic m_out  = 1'b0;

   tone_converter #(.CLK_FREQ_HZ(1_000_000)) dut (
      .CLK   (CLK),
      .RST   (RST),
      .EN    (EN),
      .B_in  (B_in),
      .D_out (D_out)
   );

   always #50 CLK = ~CLK;

   function automatic int half_of(input int k);
      return 1_000_000 / (2 * int'(hz[k]));
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input logic en, input logic [3:0] b);
      if (!en || b == 4'd0 || int'(b) != m_prev) begin
         m_age = 0;
         m_out = 1'b0;
      end else begin
         m_age++;
         m_out = ((m_age / half_of(int'(b))) % 2) == 1;
      end
      m_prev = int'(b);
   endtask

   task automatic model_reset();
      m_age  = 0;
      m_prev = 0;
      m_out  = 1'b0;
   endtask

   // Called at a negedge; drives inputs, models the edge, returns at next negedge.
   task automatic cycle(input logic en, input logic [3:0] b);
      EN   = en;
      B_in = b;
      @(posedge CLK);
      model_step(en, b);
      exp_q.push_back(m_out);
      @(negedge CLK);
   endtask

   task automatic run_until(input logic en, input logic [3:0] b, input logic val,
                            input int bound, output int n);
      n = 0;
      do begin
         cycle(en, b);
         n++;
      end while (D_out !== val && n < bound);
      if (D_out !== val) check("timeout", int'(D_out), int'(val));
   endtask

   always @(negedge CLK) begin
      if (exp_q.size() > 0) begin
         logic e;
         e = exp_q.pop_front();
         check("dout", int'(D_out), int'(e));
      end
   end

   initial begin
      int n, hi, lo, highs;

      // Reset held with an active note: output must stay low.
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         check("reset_hold", int'(D_out), 0);
      end
      RST = 1'b1;
      model_reset();

      // Basic tone on code 3, B_in settled before EN rises.
      cycle(1'b0, 4'd3);
      cycle(1'b0, 4'd3);
      run_until(1'b1, 4'd3, 1'b1, 5000, n);
      check("rise_c3", n, 1515);
      run_until(1'b1, 4'd3, 1'b0, 5000, hi);
      check("high_c3", hi, 1515);
      run_until(1'b1, 4'd3, 1'b1, 5000, lo);
      check("low_c3", lo, 1515);

      // Note change mid-tone to code 15.
      for (int i = 0; i < 100; i++) cycle(1'b1, 4'd3);
      cycle(1'b1, 4'd15);
      check("change_zero", int'(D_out), 0);
      run_until(1'b1, 4'd15, 1'b1, 5000, n);
      check("rise_c15", n, 477);
      run_until(1'b1, 4'd15, 1'b0, 5000, hi);
      run_until(1'b1, 4'd15, 1'b1, 5000, lo);
      check("period_c15", hi + lo, 954);

      // Extremes: code 1 and code 6, period and duty.
      cycle(1'b0, 4'd1);
      run_until(1'b1, 4'd1, 1'b1, 5000, n);
      check("rise_c1", n, 1908);
      run_until(1'b1, 4'd1, 1'b0, 5000, hi);
      run_until(1'b1, 4'd1, 1'b1, 5000, lo);
      check("period_c1", hi + lo, 3816);
      check("duty_c1", hi, lo);

      cycle(1'b0, 4'd6);
      run_until(1'b1, 4'd6, 1'b1, 5000, n);
      run_until(1'b1, 4'd6, 1'b0, 5000, hi);
      run_until(1'b1, 4'd6, 1'b1, 5000, lo);
      check("period_c6", hi + lo, 2272);
      check("duty_c6", hi, lo);

      // Enable gap of 3 cycles during the high phase.
      for (int i = 0; i < 200; i++) cycle(1'b1, 4'd6);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 4'd6);
         check("en_gap", int'(D_out), 0);
      end
      run_until(1'b1, 4'd6, 1'b1, 5000, n);
      check("reenable_rise", n, 1136);

      // Asynchronous reset mid-tone, away from any clock edge.
      for (int i = 0; i < 50; i++) cycle(1'b1, 4'd6);
      #10 RST = 1'b0;
      #1 check("async_reset", int'(D_out), 0);
      model_reset();
      repeat (3) @(negedge CLK);
      check("reset_mid_hold", int'(D_out), 0);
      RST = 1'b1;

      // Silence: code 0 while enabled, then disabled with a real note.
      highs = 0;
      for (int i = 0; i < 4000; i++) begin
         cycle(1'b1, 4'd0);
         if (D_out === 1'b1) highs++;
      end
      check("silence_b0", highs, 0);
      highs = 0;
      for (int i = 0; i < 4000; i++) begin
         cycle(1'b0, 4'd6);
         if (D_out === 1'b1) highs++;
      end
      check("silence_en0", highs, 0);

      // Random segments of held notes, enables and silences.
      for (int s = 0; s < 14; s++) begin
         logic       en;
         logic [3:0] b;
         int         len;
         en  = ($urandom_range(0, 7) != 0);
         b   = 4'($urandom_range(0, 15));
         len = $urandom_range(1, 1500);
         for (int i = 0; i < len; i++) cycle(en, b);
      end

      @(negedge CLK);
      check("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tone_converter.md
# tone_converter

Square-wave tone generator for the LaunchPad sound path. Converts a 4-bit note code (`B_in`) into a 50 %-duty square wave on `D_out` that drives the piezo/speaker output. It sits between the keypad/note decoder and the audio pin. It is silent when disabled or when the code is 0.

## Interface
Parameters:
- `CLK_FREQ_HZ`, default 1_000_000: input clock frequency in Hz; all note divisors derive from it.
- `CNT_W`, default derived: counter width, set to clog2 of the largest half-period (code 1). It is 11 bits at the default clock.

Ports:
- `CLK`, input, 1 bit: single system clock; all logic on its rising edge.
- `RST`, input, 1 bit: asynchronous, active-low reset.
- `EN`, input, 1 bit: tone enable. Level-sensitive and sampled on `CLK`.
- `B_in`, input, 4 bits: note code. 0 means silence; 1..15 select notes.
- `D_out`, output, 1 bit: registered square-wave output.

## Operation
- Note map (code → Hz), octave C4..C6 major scale:
  - 1=262, 2=294, 3=330, 4=349, 5=392
  - 6=440, 7=494, 8=523, 9=587, 10=659
  - 11=698, 12=784, 13=880, 14=988, 15=1047
- Half-period per code: `HALF(k) = CLK_FREQ_HZ / (2*f_k)`, integer floor division, computed at elaboration.
  - Example at 1 MHz: `HALF(1)=1908`, `HALF(3)=1515`, `HALF(6)=1136`, `HALF(15)=477`.
- Internal registers: `cnt[CNT_W-1:0]`, `code_q[3:0]`, and `D_out`.
- Per rising edge, in priority order:
  1. `EN=0` or `B_in=0`: `cnt←0`, `D_out←0`, `code_q←B_in`.
  2. `B_in≠code_q` (note change): `cnt←0`, `D_out←0`, `code_q←B_in`. This restarts the phase.
  3. `cnt==HALF(B_in)-1`: `cnt←0`, `D_out←~D_out`.
  4. Otherwise: `cnt←cnt+1`.
- `cnt` never exceeds `HALF(code)-1`, so no wrap-around or overflow is possible.
- `B_in` is assumed synchronous to `CLK`; no synchronizer is included.

## Timing
- Reset values (`RST=0`, asynchronous): `cnt=0`, `code_q=0`, `D_out=0`. These hold while `RST` is low regardless of `EN` or `B_in`.
- Release of `RST` takes effect at the first rising edge after deassertion.
- Start-up: with `B_in=k` stable before `EN` rises, `D_out` rises on the HALF(k)-th rising edge with `EN=1`.
  - It then toggles every HALF(k) edges: period 2·HALF(k), exactly 50 % duty.
- `EN` dropping: `D_out=0` on the next edge. Re-enabling restarts from phase 0; no residual count is kept.
- Code change while enabled: one edge of restart (output 0, count 0). The new note's first rising edge follows HALF(new) edges later.
- Code change and `EN` drop in the same cycle: rule 1 wins and the output goes silent.
- Reset asserted mid-tone: `D_out` drops to 0 immediately, without waiting for a clock edge.
- Output is fully registered: no combinational path from inputs to `D_out`.

## Structure
- Package `tone_pkg` contains:
  - the note-frequency constant array (16 entries, index 0 unused/0);
  - function `half_period(clk_hz, code)`;
  - constant `TONE_SILENT = 4'd0`.
- Sub-module `tone_rom`: combinational lookup from code to `HALF` (CNT_W bits), built from package constants.
- The top level holds the counter, `code_q` and output toggle.

## Test plan
(`CLK_FREQ_HZ=1_000_000`, 100-time-unit clock)
- Reset: hold `RST=0` with `EN=1`, `B_in=3` → `D_out=0`. Assert `RST=0` mid-tone → `D_out` falls to 0 asynchronously.
- Basic tone: release reset, `B_in=3`, `EN=1` → `D_out` rises after 1515 edges, then high 1515 / low 1515 edges, repeating.
- Silence: `B_in=0` with `EN=1` → `D_out` stays 0 for ≥4000 cycles. `EN=0` with `B_in=6` gives the same result.
- Note change: mid-tone on code 3, switch to `B_in=15` → `D_out=0` on the next edge, then period 954 edges (477/477).
- Extremes: code 1 → period 3816 edges; code 6 → period 2272 edges. Duty is exactly 50 % in both.
- Enable toggling: drop `EN` for 3 cycles mid-high-phase, then re-raise → `D_out=0` during the gap; the first rise is HALF edges after re-enable.
